// File: rtl/ppu_timing_pkg.sv
// Shared PPU timing constants, fetch/region encodings and nametable address helpers
// for the PPU-side fetch generator.
package ppu_timing_pkg;

    localparam int DOTS_PER_LINE_DEF   = 341;
    localparam int LINES_PER_FRAME_DEF = 262;
    localparam int VBL_LINE_DEF        = 241;
    localparam int ODD_SKIP_DEF        = 1;

    localparam int BG_LAST_DOT    = 256;
    localparam int SPR_LAST_DOT   = 320;
    localparam int PRE_LAST_DOT   = 336;
    localparam int DUMMY_LAST_DOT = 340;

    typedef enum logic [1:0] {F_NT, F_AT, F_PLO, F_PHI} fetch_phase_t;
    typedef enum logic [2:0] {R_BG, R_SPR, R_PRE, R_DUMMY, R_IDLE} region_t;

    function automatic logic [13:0] nt_addr(input logic [1:0] n, input logic [4:0] r,
                                            input logic [4:0] cx);
        return {2'b10, n, r, cx};
    endfunction

    // Attribute byte covers a 4x4 tile block, hence only the top 3 bits of row/column.
    function automatic logic [13:0] at_addr(input logic [1:0] n, input logic [2:0] r_hi,
                                            input logic [2:0] cx_hi);
        return {2'b10, n, 4'hF, r_hi, cx_hi};
    endfunction

endpackage

// File: rtl/ppu_dot_counter.sv
// Dot / scanline / frame parity counter with odd-frame dot skip and vblank flag.
// dot_next/line_next expose the position the next dot strobe will move to.
module ppu_dot_counter
    import ppu_timing_pkg::*;
#(
    parameter int DOTS_PER_LINE   = DOTS_PER_LINE_DEF,
    parameter int LINES_PER_FRAME = LINES_PER_FRAME_DEF,
    parameter int VBL_LINE        = VBL_LINE_DEF,
    parameter int ODD_SKIP        = ODD_SKIP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dot_en,
    input  logic       skip_en,
    output logic [8:0] dot,
    output logic [8:0] scanline,
    output logic [8:0] dot_next,
    output logic [8:0] line_next,
    output logic       frame_odd,
    output logic       vblank
);

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_SKIP  = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] LINE_VBL  = 9'(VBL_LINE);

    logic [8:0] dot_reg;
    logic [8:0] line_reg;
    logic       frame_odd_reg;
    logic       vblank_reg;
    logic       frame_end;

    always_comb begin
        dot_next  = dot_reg + 9'd1;
        line_next = line_reg;
        frame_end = 1'b0;
        if ((ODD_SKIP != 0) && frame_odd_reg && skip_en &&
            (line_reg == LINE_LAST) && (dot_reg == DOT_SKIP)) begin
            dot_next  = '0;
            line_next = '0;
            frame_end = 1'b1;
        end else if (dot_reg == DOT_LAST) begin
            dot_next = '0;
            if (line_reg == LINE_LAST) begin
                line_next = '0;
                frame_end = 1'b1;
            end else begin
                line_next = line_reg + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dot_reg       <= '0;
            line_reg      <= '0;
            frame_odd_reg <= 1'b0;
            vblank_reg    <= 1'b0;
        end else if (dot_en) begin
            dot_reg  <= dot_next;
            line_reg <= line_next;
            if (frame_end) begin
                frame_odd_reg <= ~frame_odd_reg;
            end
            if ((line_next == LINE_VBL) && (dot_next == 9'd1)) begin
                vblank_reg <= 1'b1;
            end else if ((line_next == LINE_LAST) && (dot_next == 9'd1)) begin
                vblank_reg <= 1'b0;
            end
        end
    end

    assign dot       = dot_reg;
    assign scanline  = line_reg;
    assign frame_odd = frame_odd_reg;
    assign vblank    = vblank_reg;

endmodule

// File: rtl/ppu_fetch_gen.sv
// PPU-side bus initiator: replays the NES PPU background/sprite/prefetch/dummy-NT
// read sequence (scroll fixed at 0) so a mapper can be exercised standalone.
module ppu_fetch_gen
    import ppu_timing_pkg::*;
#(
    parameter int DOTS_PER_LINE   = DOTS_PER_LINE_DEF,
    parameter int LINES_PER_FRAME = LINES_PER_FRAME_DEF,
    parameter int VBL_LINE        = VBL_LINE_DEF,
    parameter int ODD_SKIP        = ODD_SKIP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dot_en,
    input  logic        render_en,
    input  logic [1:0]  nt_sel,
    input  logic        bg_pt,
    input  logic        spr_pt,
    input  logic        spr_16,
    input  logic [7:0]  ppu_dat,
    output logic [13:0] ppu_addr,
    output logic        ppu_oe,
    output logic        ppu_we,
    output logic [8:0]  scanline,
    output logic [8:0]  dot,
    output logic        vblank,
    output logic        frame_odd
);

    localparam logic [8:0] LAST_VIS_LINE = 9'(VBL_LINE - 2);
    localparam logic [8:0] PRE_LINE      = 9'(LINES_PER_FRAME - 1);

    logic [8:0]   dot_next;
    logic [8:0]   line_next;
    logic         render_reg;
    logic         pending_reg;
    logic         ppu_oe_reg;
    logic [13:0]  ppu_addr_reg;
    logic [7:0]   tile_reg;
    fetch_phase_t phase_reg;
    fetch_phase_t phase_next;
    region_t      region;
    logic         rend_eff;
    logic         line_active;
    logic         issue;
    logic [5:0]   tile_idx;
    logic [7:0]   cur_row;
    logic [7:0]   next_row;
    logic [7:0]   row_sel;
    logic [1:0]   nt_n;
    logic         spr_pt_sel;
    logic [13:0]  addr_next;

    ppu_dot_counter #(
        .DOTS_PER_LINE   (DOTS_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME),
        .VBL_LINE        (VBL_LINE),
        .ODD_SKIP        (ODD_SKIP)
    ) u_dot_counter (
        .clk       (clk),
        .rst       (rst),
        .dot_en    (dot_en),
        .skip_en   (render_reg),
        .dot       (dot),
        .scanline  (scanline),
        .dot_next  (dot_next),
        .line_next (line_next),
        .frame_odd (frame_odd),
        .vblank    (vblank)
    );

    // Everything below describes the fetch for the position being entered on this strobe.
    always_comb begin
        rend_eff    = (dot == 9'd0) ? render_en : render_reg;
        line_active = (line_next <= LAST_VIS_LINE) || (line_next == PRE_LINE);
        cur_row     = (line_next == PRE_LINE) ? 8'd0 : line_next[7:0];
        next_row    = (line_next == PRE_LINE) ? 8'd0 : line_next[7:0] + 8'd1;

        if (dot_next == 9'd0) begin
            region = R_IDLE;
        end else if (dot_next <= 9'(BG_LAST_DOT)) begin
            region = R_BG;
        end else if (dot_next <= 9'(SPR_LAST_DOT)) begin
            region = R_SPR;
        end else if (dot_next <= 9'(PRE_LAST_DOT)) begin
            region = R_PRE;
        end else if (dot_next <= 9'(DUMMY_LAST_DOT)) begin
            region = R_DUMMY;
        end else begin
            region = R_IDLE;
        end

        issue      = rend_eff && line_active && dot_next[0] && (region != R_IDLE);
        phase_next = fetch_phase_t'(dot_next[2:1]);
        tile_idx   = 6'd0;
        row_sel    = next_row;
        case (region)
            R_BG: begin
                tile_idx = {1'b0, dot_next[7:3]} + 6'd2;
                row_sel  = cur_row;
            end
            // Sprite slots issue two garbage NT reads where BG would read NT/AT.
            R_SPR: begin
                if (phase_next == F_AT) begin
                    phase_next = F_NT;
                end
            end
            R_PRE: tile_idx = {5'd0, dot_next[3]};
            R_DUMMY: begin
                tile_idx   = 6'd2;
                phase_next = F_NT;
            end
            default: ;
        endcase

        nt_n       = nt_sel ^ {1'b0, tile_idx[5]};
        spr_pt_sel = spr_16 | spr_pt;
        case (phase_next)
            F_NT:    addr_next = nt_addr(nt_n, row_sel[7:3], tile_idx[4:0]);
            F_AT:    addr_next = at_addr(nt_n, row_sel[7:5], tile_idx[4:2]);
            default: begin
                if (region == R_SPR) begin
                    addr_next = {1'b0, spr_pt_sel, 8'hFF, phase_next == F_PHI, 3'b000};
                end else begin
                    addr_next = {1'b0, bg_pt, tile_reg, phase_next == F_PHI, row_sel[2:0]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            render_reg   <= 1'b0;
            pending_reg  <= 1'b0;
            ppu_oe_reg   <= 1'b1;
            ppu_addr_reg <= '0;
            tile_reg     <= '0;
            phase_reg    <= F_NT;
        end else if (dot_en) begin
            if (dot == 9'd0) begin
                render_reg <= render_en;
            end
            if (!ppu_oe_reg && (phase_reg == F_NT)) begin
                tile_reg <= ppu_dat;
            end
            if (issue) begin
                ppu_addr_reg <= addr_next;
                ppu_oe_reg   <= 1'b1;
                pending_reg  <= 1'b1;
                phase_reg    <= phase_next;
            end else begin
                // Read half of a fetch; an odd-frame skip into dot 0 abandons it.
                ppu_oe_reg  <= !(pending_reg && (dot_next != 9'd0));
                pending_reg <= 1'b0;
            end
        end
    end

    assign ppu_addr = ppu_addr_reg;
    assign ppu_oe   = ppu_oe_reg;
    assign ppu_we   = 1'b1;

endmodule
